// File: rtl/voter_pkg.sv
// Shared types and constants for the voting session controller.
package voter_pkg;

   localparam int unsigned N_VOTERS = 4;

   // Bit positions inside the voter core's [3:1] classification vector
   localparam int unsigned RES_YES = 3;
   localparam int unsigned RES_TIE = 2;
   localparam int unsigned RES_NO  = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OPEN   = 2'd1,
      TALLY  = 2'd2,
      RESULT = 2'd3
   } state_t;

   // Number of set bits in a ballot-sized vector
   function automatic logic [2:0] popcount4(input logic [N_VOTERS-1:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/voter_core.sv
// Combinational 4-input majority classifier: yes majority / tie / no majority.
// Optional feature macro: VOTER_ABSTAIN_EN (cast mask excludes uncast voters,
// fewer than three cast votes gives an all-zero quorum-fail result).
import voter_pkg::*;

module voter_core (
`ifdef VOTER_ABSTAIN_EN
   input  logic [N_VOTERS-1:0] cast,
`endif
   input  logic [N_VOTERS-1:0] votes,
   output logic [3:1]          cls
);

`ifdef VOTER_ABSTAIN_EN
   logic [2:0] n_yes;
   logic [2:0] n_cast;
   logic [3:0] yes2;

   // Majority over cast votes only; compare 2*yes against the number cast
   always_comb begin
      cls    = '0;
      n_yes  = popcount4(votes & cast);
      n_cast = popcount4(cast);
      yes2   = {n_yes, 1'b0};
      if (n_cast >= 3'd3) begin
         if (yes2 > {1'b0, n_cast})
            cls[RES_YES] = 1'b1;
         else if (yes2 == {1'b0, n_cast})
            cls[RES_TIE] = 1'b1;
         else
            cls[RES_NO] = 1'b1;
      end
   end
`else
   logic [2:0] n_yes;

   // Uncast voters arrive as 0 in the ballot and therefore count as no
   always_comb begin
      cls   = '0;
      n_yes = popcount4(votes);
      if (n_yes >= 3'd3)
         cls[RES_YES] = 1'b1;
      else if (n_yes == 3'd2)
         cls[RES_TIE] = 1'b1;
      else
         cls[RES_NO] = 1'b1;
   end
`endif

endmodule

// File: rtl/voter_session_ctrl.sv
// Voting session sequencer: open, collect one acked vote per voter, close on
// all-cast or timeout, classify the registered ballot, hold result until acked.
// Optional feature macro: VOTER_ABSTAIN_EN (adds abstain output, quorum rule).
import voter_pkg::*;

module voter_session_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N_VOTERS-1:0] vote_valid,
   input  logic [N_VOTERS-1:0] vote_val,
   output logic [N_VOTERS-1:0] vote_ack,
   output logic                busy,
   output logic                result_valid,
   output logic [2:0]          result,
   input  logic                result_ack,
`ifdef VOTER_ABSTAIN_EN
   output logic [N_VOTERS-1:0] abstain,
`endif
   output logic                timed_out
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

   state_t              state;
   logic [N_VOTERS-1:0] ballot;
   logic [N_VOTERS-1:0] cast;
   logic [TMR_W-1:0]    timer;
   logic [N_VOTERS-1:0] accept;
   logic [3:1]          core_cls;

   // Voters presenting a first vote this cycle
   assign accept = vote_valid & ~cast;

   voter_core u_core (
`ifdef VOTER_ABSTAIN_EN
      .cast  (cast),
`endif
      .votes (ballot),
      .cls   (core_cls)
   );

   // Session FSM with registered outputs, ballot, cast mask and timer
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         vote_ack     <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         timed_out    <= 1'b0;
         ballot       <= '0;
         cast         <= '0;
         timer        <= '0;
`ifdef VOTER_ABSTAIN_EN
         abstain      <= '0;
`endif
      end else begin
         vote_ack <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= OPEN;
                  busy      <= 1'b1;
                  ballot    <= '0;
                  cast      <= '0;
                  timer     <= '0;
                  timed_out <= 1'b0;
               end
            end
            OPEN: begin
               ballot   <= (ballot & ~accept) | (vote_val & accept);
               cast     <= cast | accept;
               vote_ack <= accept;
               timer    <= timer + TMR_W'(1);
               if ((cast | accept) == '1) begin
                  state <= TALLY;
               end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  state     <= TALLY;
                  timed_out <= 1'b1;
               end
            end
            TALLY: begin
               result       <= core_cls;
               result_valid <= 1'b1;
`ifdef VOTER_ABSTAIN_EN
               abstain      <= ~cast;
`endif
               state        <= RESULT;
            end
            RESULT: begin
               if (result_ack) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_voter_session_ctrl.sv
// Directed testbench for voter_session_ctrl (default TIMEOUT_CYCLES = 16).
// Optional feature macro: VOTER_ABSTAIN_EN (checks abstain and quorum fail).
`timescale 1ns/1ps
module tb_voter_session_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] vote_valid;
   logic [3:0] vote_val;
   logic [3:0] vote_ack;
   logic       busy;
   logic       result_valid;
   logic [2:0] result;
   logic       result_ack;
   logic       timed_out;
`ifdef VOTER_ABSTAIN_EN
   logic [3:0] abstain;
`endif

   int tests = 0;
   int fails = 0;

   voter_session_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .vote_valid   (vote_valid),
      .vote_val     (vote_val),
      .vote_ack     (vote_ack),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result),
      .result_ack   (result_ack),
`ifdef VOTER_ABSTAIN_EN
      .abstain      (abstain),
`endif
      .timed_out    (timed_out)
   );

   always #5 clk = ~clk;

   // One clock edge, then settle so outputs are sampled away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic open_session();
      start = 1'b1;
      step();
      start = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL open_busy got %b want 1", busy); end
   endtask

   task automatic close_session();
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL close_busy got %b want 0", busy); end
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL close_rv got %b want 0", result_valid); end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; vote_valid = '0; vote_val = '0; result_ack = 1'b0;
      step(); step();
      rst = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (vote_ack !== 4'h0) begin fails++; $display("FAIL reset_ack got %b want 0000", vote_ack); end
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got %b want 0", result_valid); end
      tests++; if (result !== 3'b000) begin fails++; $display("FAIL reset_result got %b want 000", result); end
      tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL reset_to got %b want 0", timed_out); end
`ifdef VOTER_ABSTAIN_EN
      tests++; if (abstain !== 4'h0) begin fails++; $display("FAIL reset_abstain got %b want 0000", abstain); end
`endif
   endtask

   task automatic test_abort();
      open_session();
      vote_valid = 4'b0001; vote_val = 4'b0001;
      step();
      tests++; if (vote_ack !== 4'b0001) begin fails++; $display("FAIL abort_ack0 got %b want 0001", vote_ack); end
      rst = 1'b1; vote_valid = 4'b0010; vote_val = 4'b0010;
      step(); step();
      rst = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
      tests++; if (vote_ack !== 4'h0) begin fails++; $display("FAIL abort_ack got %b want 0000", vote_ack); end
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL abort_rv got %b want 0", result_valid); end
      tests++; if (result !== 3'b000) begin fails++; $display("FAIL abort_result got %b want 000", result); end
      vote_valid = 4'b0100; vote_val = 4'b0100;
      step();
      tests++; if (vote_ack !== 4'h0) begin fails++; $display("FAIL abort_late_ack got %b want 0000", vote_ack); end
      step(); step();
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL abort_no_result got %b want 0", result_valid); end
      vote_valid = '0; vote_val = '0;
   endtask

   task automatic test_majority();
      open_session();
      for (int i = 0; i < 4; i++) begin
         vote_valid = 4'(1 << i);
         vote_val   = (i < 3) ? 4'(1 << i) : 4'h0;
         step();
         tests++; if (vote_ack !== 4'(1 << i)) begin fails++; $display("FAIL maj_ack%0d got %b want %b", i, vote_ack, 4'(1 << i)); end
      end
      vote_valid = '0; vote_val = '0;
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL maj_rv_early got %b want 0", result_valid); end
      step();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL maj_rv got %b want 1", result_valid); end
      tests++; if (result !== 3'b100) begin fails++; $display("FAIL maj_result got %b want 100", result); end
      tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL maj_to got %b want 0", timed_out); end
`ifdef VOTER_ABSTAIN_EN
      tests++; if (abstain !== 4'h0) begin fails++; $display("FAIL maj_abstain got %b want 0000", abstain); end
`endif
      step();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL maj_hold got %b want 1", result_valid); end
      close_session();
      tests++; if (result !== 3'b100) begin fails++; $display("FAIL maj_retain got %b want 100", result); end
   endtask

   task automatic test_simultaneous();
      open_session();
      vote_valid = 4'hF; vote_val = 4'b0011;
      step();
      vote_valid = '0; vote_val = '0;
      tests++; if (vote_ack !== 4'hF) begin fails++; $display("FAIL sim_ack got %b want 1111", vote_ack); end
      step();
      tests++; if (vote_ack !== 4'h0) begin fails++; $display("FAIL sim_ack_pulse got %b want 0000", vote_ack); end
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL sim_rv got %b want 1", result_valid); end
      tests++; if (result !== 3'b010) begin fails++; $display("FAIL sim_result got %b want 010", result); end
      tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL sim_to got %b want 0", timed_out); end
      close_session();
   endtask

   task automatic test_timeout();
      open_session();
      vote_valid = 4'b0001; vote_val = 4'b0001;
      step();
      vote_valid = '0; vote_val = '0;
      tests++; if (vote_ack !== 4'b0001) begin fails++; $display("FAIL to_ack got %b want 0001", vote_ack); end
      for (int c = 2; c <= 15; c++) step();
      tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL to_early got %b want 0", timed_out); end
      step();
      tests++; if (timed_out !== 1'b1) begin fails++; $display("FAIL to_flag got %b want 1", timed_out); end
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL to_rv_early got %b want 0", result_valid); end
      step();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL to_rv got %b want 1", result_valid); end
`ifdef VOTER_ABSTAIN_EN
      tests++; if (result !== 3'b000) begin fails++; $display("FAIL to_result got %b want 000", result); end
      tests++; if (abstain !== 4'b1110) begin fails++; $display("FAIL to_abstain got %b want 1110", abstain); end
`else
      tests++; if (result !== 3'b001) begin fails++; $display("FAIL to_result got %b want 001", result); end
`endif
      tests++; if (timed_out !== 1'b1) begin fails++; $display("FAIL to_hold got %b want 1", timed_out); end
      close_session();
   endtask

   task automatic test_repeat_and_start();
      open_session();
      vote_valid = 4'b0100; vote_val = 4'b0000;
      step();
      tests++; if (vote_ack !== 4'b0100) begin fails++; $display("FAIL rep_first got %b want 0100", vote_ack); end
      vote_valid = 4'b0100; vote_val = 4'b0100; start = 1'b1;
      step();
      tests++; if (vote_ack !== 4'h0) begin fails++; $display("FAIL rep_second got %b want 0000", vote_ack); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rep_start_open got %b want 1", busy); end
      vote_valid = 4'b1011; vote_val = 4'b0011;
      step();
      vote_valid = '0; vote_val = '0;
      tests++; if (vote_ack !== 4'b1011) begin fails++; $display("FAIL rep_rest got %b want 1011", vote_ack); end
      step();
      tests++; if (result !== 3'b010) begin fails++; $display("FAIL rep_result got %b want 010", result); end
      step(); step();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL rep_start_result got %b want 1", result_valid); end
      result_ack = 1'b1;
      step();
      result_ack = 1'b0; start = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rep_ack_start got %b want 0", busy); end
      step();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rep_idle got %b want 0", busy); end
   endtask

   task automatic test_timeout_late_vote();
      open_session();
      vote_valid = 4'b0111; vote_val = 4'b0111;
      step();
      vote_valid = '0; vote_val = '0;
      tests++; if (vote_ack !== 4'b0111) begin fails++; $display("FAIL late_first got %b want 0111", vote_ack); end
      for (int c = 2; c <= 15; c++) step();
      vote_valid = 4'b1000; vote_val = 4'b1000;
      step();
      vote_valid = '0; vote_val = '0;
      tests++; if (vote_ack !== 4'b1000) begin fails++; $display("FAIL late_ack got %b want 1000", vote_ack); end
      tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL late_to got %b want 0", timed_out); end
      step();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL late_rv got %b want 1", result_valid); end
      tests++; if (result !== 3'b100) begin fails++; $display("FAIL late_result got %b want 100", result); end
`ifdef VOTER_ABSTAIN_EN
      tests++; if (abstain !== 4'h0) begin fails++; $display("FAIL late_abstain got %b want 0000", abstain); end
`endif
      close_session();
   endtask

   initial begin
      test_reset();
      test_abort();
      test_majority();
      test_simultaneous();
      test_timeout();
      test_repeat_and_start();
      test_timeout_late_vote();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
